vend_ctrl_gen2: RTL
===================

Name: vend_ctrl_gen2

Overview:
- Second-generation vending controller with a single clock domain.
- Holds a parametrised item table with {sold, stock, price} per entry, configured through a simple synchronous config port.
- Accumulates coins/notes against the selected item's price, vends, then pays change one note per handshake using greedy denominations.
- Adds behaviour the first generation lacked: cancel and inactivity-timeout refunds, credit-overflow coin rejection, and handshaked multi-note change.

Parameters:
- K, 64, number of items / table depth.
- D, 6, item code width; must equal $clog2(K).
- N, 7, note/coin value width.
- PRICE_W, 16, price and credit width.
- MAX_CREDIT, 500, maximum accepted credit; must be less than 2^PRICE_W.
- TIMEOUT_CYC, 1000, idle cycles allowed in COLLECT before auto-refund; must be at least 1.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- cfg_en  in  1  config access strobe.
- cfg_wr  in  1  1 = write, 0 = read.
- cfg_addr  in  D  table index.
- cfg_wdata  in  32  entry data: [31:24] sold, [23:16] stock, [15:0] price.
- cfg_rdata  out  32  read data, valid 1 cycle after the read strobe.
- cfg_err  out  1  pulse: access rejected because FSM is not IDLE.
- sel_valid  in  1  item select strobe.
- sel_code  in  D  selected item.
- item_na  out  1  pulse: selected stock is 0.
- coin_valid  in  1  coin/note inserted.
- coin_val  in  N  value of inserted coin/note.
- coin_rej  out  1  pulse: coin returned.
- cancel  in  1  user cancel.
- o_valid  out  1  pulse: item dispensed.
- output_item  out  D  dispensed item code.
- chg_valid  out  1  change note available.
- chg_note  out  N  value of current change note.
- chg_ready  in  1  dispenser accepts the current note.
- busy  out  1  FSM is not IDLE.

Behaviour:
- Reset: rstn low at a clk edge forces the following, regardless of state (reset mid-operation loses credit silently):
  - FSM to IDLE.
  - All outputs to 0.
  - credit, remaining and timer to 0.
  - All table entries to 0.
- States: IDLE, READ, CHECK, COLLECT, VEND, CHANGE.
- IDLE:
  - cfg_en has priority over sel_valid; sel_valid is ignored in a cycle where cfg_en is 1.
  - Config write updates the entry at the clock edge.
  - Config read returns cfg_rdata on the next cycle.
  - sel_valid latches sel_code and moves to READ.
- Config outside IDLE: the access is ignored, cfg_err pulses for 1 cycle, and the table is unchanged.
- READ: registered table read (1 cycle), then CHECK.
- CHECK:
  - stock == 0: item_na pulses, then IDLE.
  - Otherwise: credit is cleared, timer is cleared, then COLLECT.
- COLLECT:
  - Coin acceptance:
    - coin_valid with credit+coin_val <= MAX_CREDIT: credit is incremented and timer is cleared.
    - Otherwise: coin_rej pulses the next cycle and credit is unchanged.
  - Cancel:
    - cancel has priority over a coin in the same cycle; that coin is rejected.
    - On cancel: remaining = credit, then CHANGE, or IDLE if credit is 0.
  - Timeout: the timer increments each cycle without a coin. When it reaches TIMEOUT_CYC, the controller refunds exactly as for cancel.
  - Purchase: when registered credit >= price, go to VEND.
    - A coin arriving in the same cycle as that comparison is still accepted.
    - It simply increases the change.
    - A price of 0 vends on the first COLLECT cycle.
- VEND, single cycle:
  - o_valid=1 and output_item=latched code.
  - Write back stock-1, and sold+1 saturating at 255.
  - remaining = credit - price.
  - Next state is CHANGE if remaining != 0, else IDLE.
- CHANGE:
  - chg_valid=1 and chg_note = the largest denomination <= remaining.
  - chg_note is stable while chg_ready is 0.
  - On chg_valid & chg_ready, remaining -= chg_note.
  - When remaining reaches 0, chg_valid drops in the same cycle the FSM returns to IDLE.
  - cancel, coin and sel inputs are ignored; coins are rejected with coin_rej.
- Width rules:
  - credit and remaining are PRICE_W bits and are unsigned.
  - The greedy algorithm always terminates because 1 is a denomination.
- busy = (state != IDLE).

Decomposition:
- Package vend_pkg holds:
  - The state enum.
  - The denomination constant array {100,50,20,10,5,2,1}.
  - Entry field offsets (SOLD_MSB etc.).
  - A function largest_denom(remaining) returning an N-bit value.
- One sub-module, vend_item_table: a K×32 flop array with a synchronous write port, a 1-cycle read port, and synchronous clear on rstn.
- The FSM and the arithmetic stay in vend_ctrl_gen2.

Test Plan:
- Reset, then configure item 5 = {sold 0, stock 2, price 35} and read it back.
  - Required: cfg_rdata = 0x00020023 one cycle after the read strobe.
- Select 5, insert 20 then 20.
  - Required: o_valid with output_item=5.
  - Required: chg_note 5 with chg_ready held high.
  - Required: readback of entry 5 = 0x01010023.
- Select an item with stock 0.
  - Required: item_na pulses 3 cycles after sel_valid; FSM returns to IDLE; no o_valid.
- Credit 100, then insert 100 toward price 150 with MAX_CREDIT 150.
  - Required: the second coin is rejected via coin_rej.
  - Required: cancel then refunds a single 100 note.
- Insert 7, then idle for TIMEOUT_CYC cycles.
  - Required: refund chg_note sequence 5, 2.
  - Stall chg_ready low for 3 cycles on the first note; chg_note must hold 5 throughout.
- Credit 88 toward price 10, asserting rstn low mid-CHANGE.
  - Required: outputs 0 and busy 0 on the next cycle.
  - Required: table cleared (every readback returns 0).

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: FSM states, note denominations,
// item table entry layout and the greedy change selector.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE
    } state_e;

    localparam int NOTE_W    = 7;
    localparam int NUM_DENOM = 7;
    localparam logic [NOTE_W-1:0] DENOMS [NUM_DENOM] =
        '{7'd100, 7'd50, 7'd20, 7'd10, 7'd5, 7'd2, 7'd1};

    localparam int SOLD_MSB  = 31;
    localparam int SOLD_LSB  = 24;
    localparam int STOCK_MSB = 23;
    localparam int STOCK_LSB = 16;
    localparam int PRICE_MSB = 15;
    localparam int PRICE_LSB = 0;

    // Walks from the smallest note upward so the last fit wins; returns 0 for remaining == 0.
    function automatic logic [NOTE_W-1:0] largest_denom(input logic [31:0] remaining);
        logic [NOTE_W-1:0] note;
        note = '0;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (remaining >= {{(32-NOTE_W){1'b0}}, DENOMS[i]}) begin
                note = DENOMS[i];
            end
        end
        return note;
    endfunction

endpackage

// File: rtl/vend_item_table.sv
// K x 32 item table: {sold, stock, price} per entry.
// One synchronous write port, one registered read port (data valid the cycle after rd_en).
module vend_item_table
    import vend_pkg::*;
#(
    parameter int K = 64,
    parameter int D = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [D-1:0]  wr_addr,
    input  logic [31:0]   wr_dat,
    input  logic          rd_en,
    input  logic [D-1:0]  rd_addr,
    output logic [31:0]   rd_dat
);

    logic [31:0] mem_q [K];
    logic [31:0] mem_d [K];
    logic [31:0] rd_dat_q;
    logic [31:0] rd_dat_d;

    always_comb begin
        mem_d    = mem_q;
        rd_dat_d = rd_dat_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_dat;
        end
        if (rd_en) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < K; i++) begin
                mem_q[i] <= '0;
            end
            rd_dat_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/vend_ctrl_gen2.sv
// Vending controller: item select, coin collection with overflow reject, cancel/timeout refund,
// vend with table write-back, and greedy change paid one note per chg_valid/chg_ready handshake.
module vend_ctrl_gen2
    import vend_pkg::*;
#(
    parameter int K           = 64,
    parameter int D           = 6,
    parameter int N           = 7,
    parameter int PRICE_W     = 16,
    parameter int MAX_CREDIT  = 500,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cfg_en,
    input  logic          cfg_wr,
    input  logic [D-1:0]  cfg_addr,
    input  logic [31:0]   cfg_wdata,
    output logic [31:0]   cfg_rdata,
    output logic          cfg_err,
    input  logic          sel_valid,
    input  logic [D-1:0]  sel_code,
    output logic          item_na,
    input  logic          coin_valid,
    input  logic [N-1:0]  coin_val,
    output logic          coin_rej,
    input  logic          cancel,
    output logic          o_valid,
    output logic [D-1:0]  output_item,
    output logic          chg_valid,
    output logic [N-1:0]  chg_note,
    input  logic          chg_ready,
    output logic          busy
);

    localparam int                 TMR_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0]        TMO_LIM = 32'(TIMEOUT_CYC);
    localparam logic [PRICE_W:0]   MAX_C   = (PRICE_W + 1)'(MAX_CREDIT);

    state_e               state_q, state_d;
    logic [D-1:0]         code_q, code_d;
    logic [PRICE_W-1:0]   credit_q, credit_d;
    logic [PRICE_W-1:0]   remaining_q, remaining_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 item_na_q, item_na_d;
    logic                 coin_rej_q, coin_rej_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 tbl_wr_en, tbl_rd_en;
    logic [D-1:0]         tbl_wr_addr, tbl_rd_addr;
    logic [31:0]          tbl_wr_dat, tbl_rd_dat;

    logic [PRICE_W-1:0]   price;
    logic [7:0]           stock, sold;
    logic [PRICE_W:0]     coin_sum;
    logic                 coin_fit;
    logic [N-1:0]         note;

    vend_item_table #(.K(K), .D(D)) u_table (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (tbl_wr_en),
        .wr_addr (tbl_wr_addr),
        .wr_dat  (tbl_wr_dat),
        .rd_en   (tbl_rd_en),
        .rd_addr (tbl_rd_addr),
        .rd_dat  (tbl_rd_dat)
    );

    // The selected entry stays in the read register from CHECK through VEND; config reads are blocked then.
    assign price    = PRICE_W'(tbl_rd_dat[PRICE_MSB:PRICE_LSB]);
    assign stock    = tbl_rd_dat[STOCK_MSB:STOCK_LSB];
    assign sold     = tbl_rd_dat[SOLD_MSB:SOLD_LSB];
    assign coin_sum = {1'b0, credit_q} + (PRICE_W + 1)'(coin_val);
    assign coin_fit = (coin_sum <= MAX_C);
    assign note     = N'(largest_denom(32'(remaining_q)));

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        credit_d    = credit_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        item_na_d   = 1'b0;
        coin_rej_d  = coin_valid;
        cfg_err_d   = cfg_en && (state_q != ST_IDLE);
        tbl_wr_en   = 1'b0;
        tbl_wr_addr = cfg_addr;
        tbl_wr_dat  = cfg_wdata;
        tbl_rd_en   = 1'b0;
        tbl_rd_addr = cfg_addr;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_en) begin
                    tbl_wr_en = cfg_wr;
                    tbl_rd_en = !cfg_wr;
                end else if (sel_valid) begin
                    code_d  = sel_code;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                tbl_rd_en   = 1'b1;
                tbl_rd_addr = code_q;
                state_d     = ST_CHECK;
            end
            ST_CHECK: begin
                if (stock == 8'd0) begin
                    item_na_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    credit_d = '0;
                    timer_d  = '0;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (credit_q >= price) begin
                    if (coin_valid && coin_fit) begin
                        credit_d   = coin_sum[PRICE_W-1:0];
                        coin_rej_d = 1'b0;
                    end
                    state_d = ST_VEND;
                end else if (cancel) begin
                    remaining_d = credit_q;
                    state_d     = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else if (coin_valid && coin_fit) begin
                    credit_d   = coin_sum[PRICE_W-1:0];
                    coin_rej_d = 1'b0;
                    timer_d    = '0;
                end else if ((32'(timer_q) + 32'd1) >= TMO_LIM) begin
                    remaining_d = credit_q;
                    state_d     = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_VEND: begin
                tbl_wr_en   = 1'b1;
                tbl_wr_addr = code_q;
                tbl_wr_dat  = tbl_rd_dat;
                tbl_wr_dat[STOCK_MSB:STOCK_LSB] = stock - 8'd1;
                tbl_wr_dat[SOLD_MSB:SOLD_LSB]   = (sold == 8'hFF) ? sold : sold + 8'd1;
                remaining_d = credit_q - price;
                state_d     = (remaining_d != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (chg_ready) begin
                    remaining_d = remaining_q - PRICE_W'(note);
                    if (remaining_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            credit_q    <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            item_na_q   <= 1'b0;
            coin_rej_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            credit_q    <= credit_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            item_na_q   <= item_na_d;
            coin_rej_q  <= coin_rej_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign o_valid     = (state_q == ST_VEND);
    assign output_item = o_valid ? code_q : '0;
    assign chg_valid   = (state_q == ST_CHANGE);
    assign chg_note    = chg_valid ? note : '0;
    assign cfg_rdata   = tbl_rd_dat;
    assign item_na     = item_na_q;
    assign coin_rej    = coin_rej_q;
    assign cfg_err     = cfg_err_q;

endmodule
